iicmb_wb_cmd_sequencer: RTL

- Hardware Wishbone master that sits directly upstream of the I2C multi-bus controller (iicmb_m_wb) and drives its wishbone slave port and irq.
- Accepts single-byte I2C write requests (bus id, 7-bit slave address, data byte).
- Autonomously issues the register-level sequence: Set Bus, Start, address Write, data Write, Stop. Each command is followed by wait-for-irq and a CMDR status read.
- Replaces software/BFM-driven command flow in system-level configurations.

---
 rtl/iicmb_wb_cmd_sequencer.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/iicmb_wb_cmd_sequencer.sv
// iicmb_wb_cmd_sequencer: Wishbone master in front of iicmb_m_wb that turns a
// single-byte I2C write request into the Set Bus / Start / Write addr /
// Write data / Stop command sequence, waiting for irq and reading CMDR after each.
`timescale 1ns/1ps
module iicmb_wb_cmd_sequencer #(
  parameter int unsigned WB_ADDR_WIDTH  = 2,
  parameter int unsigned WB_DATA_WIDTH  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [7:0]               req_bus_i,
  input  logic [6:0]               req_addr_i,
  input  logic [7:0]               req_data_i,
  output logic                     done_o,
  output logic [1:0]               status_o,
  output logic                     busy_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  input  logic                     irq_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

  localparam logic [7:0] CSR_INIT   = 8'hC0;
  localparam logic [7:0] CMD_SETBUS = 8'h06;
  localparam logic [7:0] CMD_START  = 8'h04;
  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_STOP   = 8'h05;

  localparam logic [1:0] RES_OK  = 2'd0;
  localparam logic [1:0] RES_NAK = 2'd1;
  localparam logic [1:0] RES_AL  = 2'd2;
  localparam logic [1:0] RES_ERR = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_STEP, ST_CMD, ST_WB_WAIT, ST_IRQ, ST_RD, ST_FINISH
  } state_t;

  typedef enum logic [2:0] {
    STEP_SETBUS, STEP_START, STEP_ADDR, STEP_DATA, STEP_STOP
  } step_t;

  typedef enum logic [1:0] {ACC_CSR, ACC_DPR, ACC_CMD, ACC_RD} acc_t;

  state_t r_state, w_state;
  step_t  r_step, w_step, w_step_inc;
  acc_t   r_acc, w_acc;

  logic [7:0]               r_bus, r_data;
  logic [6:0]               r_addr;
  logic [1:0]               r_res, w_res;
  logic [CNT_W-1:0]         r_cnt, w_cnt, w_cnt_inc;
  logic                     w_timeout;
  logic                     r_cyc, w_cyc, r_we, w_we;
  logic [WB_ADDR_WIDTH-1:0] r_adr, w_adr;
  logic [WB_DATA_WIDTH-1:0] r_dat, w_dat;
  logic                     r_ready, w_ready, r_done, w_done, r_busy, w_busy;
  logic [1:0]               r_status, w_status;
  logic                     w_latch, w_fin;
  logic [1:0]               w_fin_res;
  logic [7:0]               w_cmd, w_dpr;
  logic                     w_has_dpr;
  logic                     w_don, w_nak, w_al, w_err;
  logic                     w_unused_dat;

  // CMDR status bits of the byte returned by the current read
  assign w_don = dat_i[7];
  assign w_nak = dat_i[6];
  assign w_al  = dat_i[5];
  assign w_err = dat_i[4];
  assign w_unused_dat = ^dat_i;

  // Wait counter advances and saturates; reaching the limit is a timeout
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_timeout = (w_cnt_inc == CNT_MAX);

  // Command byte, optional DPR operand and successor for the current step
  always_comb begin
    w_cmd      = CMD_STOP;
    w_dpr      = 8'h00;
    w_has_dpr  = 1'b0;
    w_step_inc = STEP_STOP;
    case (r_step)
      STEP_SETBUS: begin
        w_cmd = CMD_SETBUS; w_dpr = r_bus; w_has_dpr = 1'b1; w_step_inc = STEP_START;
      end
      STEP_START: begin
        w_cmd = CMD_START; w_step_inc = STEP_ADDR;
      end
      STEP_ADDR: begin
        w_cmd = CMD_WRITE; w_dpr = {r_addr, 1'b0}; w_has_dpr = 1'b1; w_step_inc = STEP_DATA;
      end
      STEP_DATA: begin
        w_cmd = CMD_WRITE; w_dpr = r_data; w_has_dpr = 1'b1; w_step_inc = STEP_STOP;
      end
      default: begin
        w_cmd = CMD_STOP;
      end
    endcase
  end

  // Sequencer next-state and registered-output values
  always_comb begin
    w_state   = r_state;
    w_step    = r_step;
    w_acc     = r_acc;
    w_res     = r_res;
    w_cnt     = r_cnt;
    w_cyc     = r_cyc;
    w_we      = r_we;
    w_adr     = r_adr;
    w_dat     = r_dat;
    w_ready   = r_ready;
    w_done    = 1'b0;
    w_status  = r_status;
    w_busy    = r_busy;
    w_latch   = 1'b0;
    w_fin     = 1'b0;
    w_fin_res = RES_ERR;

    case (r_state)
      ST_INIT: begin
        w_cyc = 1'b1; w_we = 1'b1; w_adr = ADR_CSR; w_dat = WB_DATA_WIDTH'(CSR_INIT);
        w_acc = ACC_CSR; w_cnt = '0; w_state = ST_WB_WAIT;
      end
      ST_IDLE: begin
        w_ready = 1'b1;
        if (req_valid_i && r_ready) begin
          w_ready = 1'b0; w_busy = 1'b1; w_latch = 1'b1;
          w_res = RES_OK; w_step = STEP_SETBUS; w_state = ST_STEP;
        end
      end
      ST_STEP: begin
        w_cyc = 1'b1; w_we = 1'b1; w_cnt = '0; w_state = ST_WB_WAIT;
        if (w_has_dpr) begin
          w_adr = ADR_DPR; w_dat = WB_DATA_WIDTH'(w_dpr); w_acc = ACC_DPR;
        end else begin
          w_adr = ADR_CMDR; w_dat = WB_DATA_WIDTH'(w_cmd); w_acc = ACC_CMD;
        end
      end
      ST_CMD: begin
        w_cyc = 1'b1; w_we = 1'b1; w_adr = ADR_CMDR; w_dat = WB_DATA_WIDTH'(w_cmd);
        w_acc = ACC_CMD; w_cnt = '0; w_state = ST_WB_WAIT;
      end
      ST_WB_WAIT: begin
        if (ack_i) begin
          w_cyc = 1'b0; w_we = 1'b0;
          case (r_acc)
            ACC_CSR: begin w_ready = 1'b1; w_state = ST_IDLE; end
            ACC_DPR: w_state = ST_CMD;
            ACC_CMD: begin w_cnt = '0; w_state = ST_IRQ; end
            default: begin
              if (w_err) begin
                w_fin = 1'b1; w_fin_res = RES_ERR;
              end else if (w_al) begin
                w_fin = 1'b1; w_fin_res = RES_AL;
              end else if (w_nak) begin
                if (r_step == STEP_ADDR || r_step == STEP_DATA) begin
                  w_res = RES_NAK; w_step = STEP_STOP; w_state = ST_STEP;
                end else begin
                  w_fin = 1'b1; w_fin_res = RES_ERR;
                end
              end else if (w_don) begin
                if (r_step == STEP_STOP) begin
                  w_fin = 1'b1; w_fin_res = r_res;
                end else begin
                  w_step = w_step_inc; w_state = ST_STEP;
                end
              end else begin
                w_fin = 1'b1; w_fin_res = RES_ERR;
              end
            end
          endcase
        end else if (w_timeout) begin
          // A dead controller during init is retried; with a request it is reported
          w_cyc = 1'b0; w_we = 1'b0; w_cnt = w_cnt_inc;
          if (r_acc == ACC_CSR) begin
            w_state = ST_INIT;
          end else begin
            w_fin = 1'b1; w_fin_res = RES_ERR;
          end
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      ST_IRQ: begin
        if (irq_i) begin
          w_state = ST_RD;
        end else begin
          w_cnt = w_cnt_inc;
          if (w_timeout) begin
            w_fin = 1'b1; w_fin_res = RES_ERR;
          end
        end
      end
      ST_RD: begin
        w_cyc = 1'b1; w_we = 1'b0; w_adr = ADR_CMDR; w_acc = ACC_RD;
        w_cnt = '0; w_state = ST_WB_WAIT;
      end
      ST_FINISH: begin
        w_busy = 1'b0; w_ready = 1'b1; w_state = ST_IDLE;
      end
      default: w_state = ST_INIT;
    endcase

    if (w_fin) begin
      w_state  = ST_FINISH;
      w_done   = 1'b1;
      w_status = w_fin_res;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_INIT;
      r_step   <= STEP_SETBUS;
      r_acc    <= ACC_CSR;
      r_res    <= RES_OK;
      r_cnt    <= '0;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_status <= RES_OK;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_step   <= w_step;
      r_acc    <= w_acc;
      r_res    <= w_res;
      r_cnt    <= w_cnt;
      r_cyc    <= w_cyc;
      r_we     <= w_we;
      r_adr    <= w_adr;
      r_dat    <= w_dat;
      r_ready  <= w_ready;
      r_done   <= w_done;
      r_status <= w_status;
      r_busy   <= w_busy;
    end
  end

  // Request fields captured on accept
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bus  <= 8'h00;
      r_addr <= 7'h00;
      r_data <= 8'h00;
    end else if (w_latch) begin
      r_bus  <= req_bus_i;
      r_addr <= req_addr_i;
      r_data <= req_data_i;
    end
  end

  assign req_ready_o = r_ready;
  assign done_o      = r_done;
  assign status_o    = r_status;
  assign busy_o      = r_busy;
  assign cyc_o       = r_cyc;
  assign stb_o       = r_cyc;
  assign we_o        = r_we;
  assign adr_o       = r_adr;
  assign dat_o       = r_dat;

endmodule
